// File: rtl/caf_peak_sink.sv
// CAF peak sink: |z|^2 = i^2 + q^2 over num_results bins, tracks the max and its index, one report per window.
// Optional CAF_PEAK_THRESHOLD_EN adds a threshold input and a peak_detected flag carried with the report.
module caf_peak_sink #(
  parameter int i_bits      = 24,
  parameter int q_bits      = 24,
  parameter int num_results = 16,
  parameter int index_bits  = 4,
  parameter int mag_bits    = 2*i_bits+1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_axis_product_tvalid,
  input  logic signed [i_bits-1:0]     i,
  input  logic signed [q_bits-1:0]     q,
  output logic                         m_axis_product_tready,
  input  logic                         m_axis_peak_tready,
  output logic                         s_axis_peak_tvalid,
  output logic [mag_bits-1:0]          peak_mag,
  output logic [index_bits-1:0]        peak_index
`ifdef CAF_PEAK_THRESHOLD_EN
  ,
  input  logic [mag_bits-1:0]          threshold,
  output logic                         peak_detected
`endif
);

  typedef enum logic [1:0] {SEARCH, DRAIN, REPORT} state_t;

  state_t                  state_q, state_d;
  logic [index_bits-1:0]   cnt_q, cnt_d;
  logic                    tready_q, tready_d;
  logic                    xfer, last_acc, load, clr;

  // S1/S2 datapath; vld_pipe_q[0] = S1 valid, [1] = S2 valid.
  logic [1:0]              vld_pipe_q;
  logic [2:0]              last_pipe_q;
  logic [2*i_bits-1:0]     sq_i_q, sq_q_q;
  logic [index_bits-1:0]   idx1_q, idx2_q;
  logic [mag_bits-1:0]     mag2_q;

  logic [mag_bits-1:0]     max_q, max_d;
  logic [index_bits-1:0]   max_idx_q, max_idx_d;

  logic                    tvalid_q;
  logic [mag_bits-1:0]     peak_mag_q;
  logic [index_bits-1:0]   peak_idx_q;

  logic signed [2*i_bits-1:0] ie, qe;
  assign ie = {{i_bits{i[i_bits-1]}}, i};
  assign qe = {{(2*i_bits-q_bits){q[q_bits-1]}}, q};

  assign xfer     = s_axis_product_tvalid & tready_q;
  assign last_acc = (cnt_q == index_bits'(num_results-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      SEARCH: if (xfer) begin
        cnt_d = cnt_q + index_bits'(1);
        if (last_acc) state_d = DRAIN;
      end
      DRAIN: if (last_pipe_q[2]) begin
        load    = 1'b1;
        state_d = REPORT;
      end
      REPORT: if (m_axis_peak_tready) begin
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    tready_d = (state_d == SEARCH);
  end

  // Index 0 always loads so a window of all-zero magnitudes still reports bin 0.
  always_comb begin
    max_d     = max_q;
    max_idx_d = max_idx_q;
    if (clr) begin
      max_d     = '0;
      max_idx_d = '0;
    end else if (vld_pipe_q[1] && (idx2_q == '0 || mag2_q > max_q)) begin
      max_d     = mag2_q;
      max_idx_d = idx2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      cnt_q       <= '0;
      tready_q    <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      sq_i_q      <= '0;
      sq_q_q      <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      mag2_q      <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      tvalid_q    <= 1'b0;
      peak_mag_q  <= '0;
      peak_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tready_q    <= tready_d;
      vld_pipe_q  <= {vld_pipe_q[0], xfer};
      last_pipe_q <= {last_pipe_q[1:0], xfer & last_acc};
      if (xfer) begin
        sq_i_q <= ie * ie;
        sq_q_q <= qe * qe;
        idx1_q <= cnt_q;
      end
      if (vld_pipe_q[0]) begin
        mag2_q <= {1'b0, sq_i_q} + {1'b0, sq_q_q};
        idx2_q <= idx1_q;
      end
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      if (load) begin
        tvalid_q   <= 1'b1;
        peak_mag_q <= max_q;
        peak_idx_q <= max_idx_q;
      end else if (clr) begin
        tvalid_q   <= 1'b0;
      end
    end
  end

`ifdef CAF_PEAK_THRESHOLD_EN
  logic det_q;
  always_ff @(posedge clk) begin
    if (rst)       det_q <= 1'b0;
    else if (load) det_q <= (max_q > threshold);
  end
  assign peak_detected = det_q;
`endif

  assign m_axis_product_tready = tready_q;
  assign s_axis_peak_tvalid    = tvalid_q;
  assign peak_mag              = peak_mag_q;
  assign peak_index            = peak_idx_q;

endmodule
